line_buffer_5: RTL and testbench
================================

# line_buffer_5

Raster-to-column front end for the 5x5 `convolution` block. It buffers four previous video lines in block RAM and presents five vertically aligned pixels per clock on `vect_o_0..4`, together with delayed `dv_o`, `hs_o` and `vs_o`. It also streams the 25 kernel coefficients on `coeff_o` during vertical sync, in the order the convolution's coefficient loader captures them. It sits between the HDMI receiver pixel output and the `convolution` inputs.

## Interface
- `COLORDEPTH`, 8: pixel width.
- `SCREENWIDTH`, 1600: maximum active pixels per line, which is the RAM depth per line.
- `ADDRW`, 11: column counter width, with 2^ADDRW >= SCREENWIDTH.
- `clk` in 1: pixel clock. All logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `px_i` in COLORDEPTH: input pixel.
- `dv_i`, `hs_i`, `vs_i` in 1 each: data valid, horizontal sync and vertical sync of the input stream.
- `vect_o_0`..`vect_o_4` out COLORDEPTH each: `vect_o_0` is the current line. `vect_o_k` is the same column k lines earlier.
- `dv_o`, `hs_o`, `vs_o` out 1 each: input strobes delayed to match the vectors.
- `lines_o` out 3: completed lines since the last `vs_i` rising edge, saturating at 4.
- `ovf_o` out 1: sticky line-overflow flag.
- `coeff_o` out 16: coefficient stream, s7.8 format.
- `cfg_we` in 1, `cfg_addr` in 5, `cfg_data` in 16: host coefficient write port.

## Operation
- **Column counter `col`.**
  - Increments on every cycle with `dv_i` high.
  - Cleared on the cycle after `dv_i` falls, and while `vs_i` is high.
- **Line storage.**
  - Four RAMs, L1..L4, each SCREENWIDTH x COLORDEPTH, read-before-write at address `col`.
  - On a `dv_i` cycle, `px_i` is written to L1 and the old L_k data is written to L_(k+1) at the same address, forming a cascade.
- **Line counter.**
  - `lines_o` increments at each `dv_i` falling edge, saturating at 4.
  - It clears on the `vs_i` rising edge.
- **Row masking.** `vect_o_k` for k = 1..4 outputs 0 while `lines_o` < k. RAM contents are never cleared; the mask alone hides stale data.
- **Overflow.**
  - If `dv_i` is high with `col` == SCREENWIDTH-1 already written, further pixels of that line are dropped and `col` holds.
  - `ovf_o` is then set. It clears only on reset.
- **Sync handling.**
  - `hs_i` and `vs_i` are passed through, delayed.
  - Pixels with `dv_i` low are never written.
- **Coefficient bank.**
  - A shadow bank of 25 x 16 is written by `cfg_we` when `cfg_addr` < 25. Writes with `cfg_addr` >= 25 are ignored.
  - The shadow bank is copied to the active bank on the `vs_i` rising edge.
  - A write in that same cycle updates the shadow bank only and takes effect next frame.
- **Coefficient stream.**
  - `coeff_o` = active[0] in the first cycle `vs_o` is high, then active[1], active[2] and so on, one per cycle, up to active[24].
  - After active[24], `coeff_o` is 0 until `vs_o` falls.
  - If `vs_o` falls early, the sequence aborts and restarts at index 0 on the next `vs_o` rise.

## Timing
- Latency is exactly 1 cycle from inputs to all outputs. All outputs are registered, and the RAM read is registered.
- `vect_o_*`, `dv_o`, `hs_o`, `vs_o` and `coeff_o` are mutually aligned.
- Reset (`rst` low) sets every output to 0 and clears `col`, `lines_o`, `ovf_o`, the coefficient index and both banks.
- Reset mid-line: the next frame starts clean. Rows remain masked until 4 new lines complete after the first `vs_i`.
- `dv_i` falling and `vs_i` rising in the same cycle: the line count increments first, then clears. Net `lines_o` = 0.
- Maximum throughput is one pixel per clock. There is no backpressure.

## Configuration
- `LINEBUF_COEFF_EN`
  - **Defined:** the coefficient bank, the `cfg_*` port and the stream behave as described above.
  - **Undefined:** the bank logic is removed, the `cfg_*` inputs are ignored, and `coeff_o` is the identity kernel: 16'h0100 at index 12, 0 at all other indices. It follows the same `vs_o`-relative sequencing.

## Test plan
- **Fill sequence.** Stimulus: 6 lines of 1600 pixels, each pixel = line number (1..6), after a `vs_i` pulse. Required response:
  - Line 3: `vect_o_0..4` = 3,2,1,0,0.
  - Line 6: `vect_o_0..4` = 6,5,4,3,2.
  - `lines_o` saturates at 4.
- **Latency and alignment.** Stimulus: a single pixel 8'hA5 at column 0. Required response: `vect_o_0` = 8'hA5 and `dv_o` high exactly 1 cycle later.
- **Overflow.** Stimulus: a line of 1605 valid pixels. Required response:
  - `ovf_o` goes high.
  - Columns 0..1599 are intact on the next line.
  - The following line is aligned correctly from column 0.
- **Coefficient stream.** Stimulus: write entry i = i+16'h0100 for all 25 entries, then hold `vs_i` high for 30 cycles. Required response: `coeff_o` steps 16'h0100..16'h0118 starting at the first `vs_o` cycle, then shows 0 for 5 cycles.
- **Bank swap race.** Stimulus: `cfg_we` to address 0 with value 16'h7FFF in the `vs_i` rising-edge cycle. Required response: the current frame streams the old active[0]; the next frame streams 16'h7FFF.
- **Mid-frame reset.** Stimulus: `rst` pulsed low during line 3, then normal frames resume. Required response:
  - All outputs are 0 during the reset.
  - Rows are masked again until 4 lines complete.

Source files
------------

// File: rtl/line_buffer_5_if.sv
// Pixel-stream, column-vector and coefficient-config bundle around line_buffer_5.
interface line_buffer_5_if #(parameter int COLORDEPTH = 8);
  logic [COLORDEPTH-1:0] px_i;
  logic                  dv_i, hs_i, vs_i;
  logic                  cfg_we;
  logic [4:0]            cfg_addr;
  logic [15:0]           cfg_data;
  logic [COLORDEPTH-1:0] vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4;
  logic                  dv_o, hs_o, vs_o;
  logic [2:0]            lines_o;
  logic                  ovf_o;
  logic [15:0]           coeff_o;

  modport master (
    output px_i, dv_i, hs_i, vs_i, cfg_we, cfg_addr, cfg_data,
    input  vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4,
    input  dv_o, hs_o, vs_o, lines_o, ovf_o, coeff_o
  );
  modport slave (
    input  px_i, dv_i, hs_i, vs_i, cfg_we, cfg_addr, cfg_data,
    output vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4,
    output dv_o, hs_o, vs_o, lines_o, ovf_o, coeff_o
  );
endinterface

// File: rtl/line_buffer_5.sv
// Four-line raster buffer giving a 5-pixel column per clock, plus a 25-entry kernel
// coefficient stream during vsync. Define LINEBUF_COEFF_EN for the programmable bank.
module line_buffer_5 #(
  parameter int COLORDEPTH  = 8,
  parameter int SCREENWIDTH = 1600,
  parameter int ADDRW       = 11
) (
  input  logic           clk,
  input  logic           rst,
  line_buffer_5_if.slave bus
);
  localparam int ROWS  = 4;
  localparam int NCOEF = 25;
  typedef logic [COLORDEPTH-1:0] px_t;

  logic [ADDRW-1:0] col_q, col_d;
  logic             full_q, full_d, ovf_q, ovf_d, sync_q, sync_d;
  logic [2:0]       lines_q, lines_d;
  logic             dv_q, hs_q, vs_q;
  px_t [ROWS:0]     vect_q, vect_d;
  logic [4:0]       idx_q, idx_d;
  logic [15:0]      coeff_q, coeff_d, coef_sel;
  px_t              rd [ROWS];
  logic             wr_en, dv_fall, vs_rise;

  assign dv_fall = dv_q & ~bus.dv_i;
  assign vs_rise = bus.vs_i & ~vs_q;
  assign wr_en   = bus.dv_i & ~full_q;

  // Read-before-write cascade: each row's old content moves one row down.
  for (genvar k = 0; k < ROWS; k++) begin : g_row
    px_t ram [SCREENWIDTH];
    px_t wdata;
    if (k == 0) begin : g_in
      assign wdata = bus.px_i;
    end else begin : g_casc
      assign wdata = rd[k-1];
    end
    assign rd[k] = ram[col_q];
    always_ff @(posedge clk) begin
      if (wr_en) ram[col_q] <= wdata;
    end
  end

  always_comb begin
    col_d   = col_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    sync_d  = sync_q | vs_rise;
    lines_d = lines_q;
    if (bus.vs_i || !bus.dv_i) begin
      col_d  = '0;
      full_d = 1'b0;
    end else if (full_q) begin
      ovf_d = 1'b1;
    end else if (col_q == ADDRW'(SCREENWIDTH - 1)) begin
      full_d = 1'b1;
    end else begin
      col_d = col_q + ADDRW'(1);
    end
    // Lines only count once a vsync has been seen, so a reset mid-line starts clean.
    if (vs_rise)
      lines_d = '0;
    else if (dv_fall && sync_q && lines_q != 3'd4)
      lines_d = lines_q + 3'd1;
    vect_d[0] = bus.px_i;
    for (int k = 1; k <= ROWS; k++)
      vect_d[k] = (lines_q >= 3'(k)) ? rd[k-1] : '0;
  end

  always_comb begin
    idx_d   = '0;
    coeff_d = '0;
    if (bus.vs_i) begin
      idx_d = idx_q;
      if (idx_q < 5'(NCOEF)) begin
        coeff_d = coef_sel;
        idx_d   = idx_q + 5'd1;
      end
    end
  end

`ifdef LINEBUF_COEFF_EN
  logic [NCOEF-1:0][15:0] shadow_q, shadow_d, active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = vs_rise ? shadow_q : active_q;
    if (bus.cfg_we && bus.cfg_addr < 5'(NCOEF))
      shadow_d[bus.cfg_addr] = bus.cfg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // On the swap cycle the active bank is not loaded yet, so read the shadow directly.
  assign coef_sel = vs_rise ? shadow_q[idx_q] : active_q[idx_q];
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.cfg_we, bus.cfg_addr, bus.cfg_data};
  assign coef_sel   = (idx_q == 5'd12) ? 16'h0100 : 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
      lines_q <= '0;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      vect_q  <= '0;
      idx_q   <= '0;
      coeff_q <= '0;
    end else begin
      col_q   <= col_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
      lines_q <= lines_d;
      dv_q    <= bus.dv_i;
      hs_q    <= bus.hs_i;
      vs_q    <= bus.vs_i;
      vect_q  <= vect_d;
      idx_q   <= idx_d;
      coeff_q <= coeff_d;
    end
  end

  assign bus.vect_o_0 = vect_q[0];
  assign bus.vect_o_1 = vect_q[1];
  assign bus.vect_o_2 = vect_q[2];
  assign bus.vect_o_3 = vect_q[3];
  assign bus.vect_o_4 = vect_q[4];
  assign bus.dv_o     = dv_q;
  assign bus.hs_o     = hs_q;
  assign bus.vs_o     = vs_q;
  assign bus.lines_o  = lines_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.coeff_o  = coeff_q;
endmodule

// File: tb/tb_line_buffer_5.sv
// Bench for line_buffer_5: vector table, directed corner sequences and random frames
// checked each cycle against a per-column pixel-history reference model.
module tb_line_buffer_5;
  localparam int CD = 8;
  localparam int SW = 1600;
  localparam int NC = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_5_if #(.COLORDEPTH(CD)) bus ();
  line_buffer_5 #(.COLORDEPTH(CD), .SCREENWIDTH(SW), .ADDRW(11)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [7:0] v_o [5];
  assign v_o[0] = bus.vect_o_0;
  assign v_o[1] = bus.vect_o_1;
  assign v_o[2] = bus.vect_o_2;
  assign v_o[3] = bus.vect_o_3;
  assign v_o[4] = bus.vect_o_4;

  int checks = 0;
  int failures = 0;

  // Reference model: the last four pixels ever written to each column, newest first.
  logic [7:0]  hist [SW][4];
  int          hcnt [SW];
  int          m_n, m_lines, m_run;
  bit          m_sync, m_ovf, m_pdv, m_pvs;
  logic [15:0] m_shadow [NC];
  logic [15:0] m_active [NC];

  logic [7:0]  e_v [5];
  bit          e_known [5];
  logic        e_dv, e_hs, e_vs, e_ovf;
  logic [2:0]  e_lines;
  logic [15:0] e_coeff;

  typedef struct {
    logic [7:0] px;
    logic dv, hs, vs;
    logic [7:0] ev0;
    logic edv, ehs, evs;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] coef_at(input int i);
`ifdef LINEBUF_COEFF_EN
    return m_active[i];
`else
    return (i == 12) ? 16'h0100 : 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    m_n = 0; m_lines = 0; m_run = 0;
    m_sync = 0; m_ovf = 0; m_pdv = 0; m_pvs = 0;
    for (int i = 0; i < NC; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
  endtask

  task automatic model_step(input logic [7:0] px, input logic dv, hs, vs, we,
                            input logic [4:0] addr, input logic [15:0] data);
    bit rise, fall;
    int c;
    rise = vs && !m_pvs;
    fall = m_pdv && !dv;
    e_dv = dv; e_hs = hs; e_vs = vs;
    for (int k = 0; k < 5; k++) begin e_v[k] = '0; e_known[k] = 0; end
    if (dv) begin
      c = (m_n < SW) ? m_n : SW - 1;
      e_v[0] = px; e_known[0] = 1;
      for (int k = 1; k < 5; k++) begin
        if (m_lines < k) begin e_v[k] = '0; e_known[k] = 1; end
        else if (hcnt[c] >= k) begin e_v[k] = hist[c][k-1]; e_known[k] = 1; end
      end
      if (m_n < SW) begin
        for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = px;
        if (hcnt[c] < 4) hcnt[c]++;
        m_n++;
      end else m_ovf = 1;
    end
    if (!dv || vs) m_n = 0;
    if (rise) m_lines = 0;
    else if (fall && m_sync && m_lines < 4) m_lines++;
    if (rise) m_sync = 1;
    if (vs) begin
      if (rise) begin
        for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
        m_run = 0;
      end
      e_coeff = (m_run < NC) ? coef_at(m_run) : 16'h0000;
      if (m_run < NC) m_run++;
    end else begin
      e_coeff = '0; m_run = 0;
    end
    if (we && addr < NC) m_shadow[addr] = data;
    m_pdv = dv; m_pvs = vs;
    e_lines = 3'(m_lines); e_ovf = m_ovf;
  endtask

  task automatic cyc(input logic [7:0] px, input logic dv, hs, vs, we,
                     input logic [4:0] addr, input logic [15:0] data);
    bus.px_i = px; bus.dv_i = dv; bus.hs_i = hs; bus.vs_i = vs;
    bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_data = data;
    model_step(px, dv, hs, vs, we, addr, data);
    @(posedge clk); #1;
    chk("dv_o", bus.dv_o, e_dv);
    chk("hs_o", bus.hs_o, e_hs);
    chk("vs_o", bus.vs_o, e_vs);
    chk("lines_o", bus.lines_o, e_lines);
    chk("ovf_o", bus.ovf_o, e_ovf);
    chk("coeff_o", bus.coeff_o, e_coeff);
    for (int k = 0; k < 5; k++)
      if (e_known[k]) chk($sformatf("vect_o_%0d", k), v_o[k], e_v[k]);
  endtask

  task automatic pix(input logic [7:0] px); cyc(px, 1, 0, 0, 0, 5'd0, 16'h0); endtask
  task automatic idle(input int n); repeat (n) cyc(8'h00, 0, 0, 0, 0, 5'd0, 16'h0); endtask
  task automatic vsync(input int n); repeat (n) cyc(8'h00, 0, 0, 1, 0, 5'd0, 16'h0); endtask
  task automatic hblank(); cyc(8'h00, 0, 1, 0, 0, 5'd0, 16'h0); idle(2); endtask

  task automatic rcyc(input logic [7:0] px, input logic dv, hs, vs);
    logic we; logic [4:0] a; logic [15:0] d;
    we = ($urandom_range(0, 5) == 0);
    a  = 5'($urandom_range(0, 31));
    d  = 16'($urandom);
    cyc(px, dv, hs, vs, we, a, d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dv"}, bus.dv_o, 0);
    chk({tag, "_hs"}, bus.hs_o, 0);
    chk({tag, "_vs"}, bus.vs_o, 0);
    chk({tag, "_lines"}, bus.lines_o, 0);
    chk({tag, "_ovf"}, bus.ovf_o, 0);
    chk({tag, "_coeff"}, bus.coeff_o, 0);
    for (int k = 0; k < 5; k++) chk($sformatf("%s_v%0d", tag, k), v_o[k], 0);
  endtask

  task automatic do_reset(input string tag);
    bus.px_i = '0; bus.dv_i = 0; bus.hs_i = 0; bus.vs_i = 0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    rst = 0; #1;
    chk_zero(tag);
    @(posedge clk); #1;
    chk_zero(tag);
    model_reset();
    @(negedge clk); rst = 1;
  endtask

  function automatic logic [7:0] pat(input int n);
    logic [10:0] nn;
    nn = 11'(n);
    return nn[7:0] ^ 8'h5A;
  endfunction

  initial begin
    int vl, nl, ll;
    for (int i = 0; i < SW; i++) hcnt[i] = 0;
    model_reset();
    #3;
    do_reset("reset");

    // Vector table: single-pixel latency/alignment plus strobe pass-through.
    tbl[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].px, tbl[i].dv, tbl[i].hs, tbl[i].vs, 0, 5'd0, 16'h0);
      chk($sformatf("tbl%0d_dv", i), bus.dv_o, tbl[i].edv);
      chk($sformatf("tbl%0d_hs", i), bus.hs_o, tbl[i].ehs);
      chk($sformatf("tbl%0d_vs", i), bus.vs_o, tbl[i].evs);
      if (tbl[i].edv) chk($sformatf("tbl%0d_v0", i), v_o[0], tbl[i].ev0);
    end

    // Fill: six full lines, each pixel equal to its line number.
    vsync(3); idle(2);
    for (int L = 1; L <= 6; L++) begin
      for (int c = 0; c < SW; c++) begin
        pix(8'(L));
        if (c == 800 && L == 3)
          for (int k = 0; k < 5; k++) chk($sformatf("fill3_v%0d", k), v_o[k], (k <= 2) ? 3 - k : 0);
        if (c == 800 && L == 6)
          for (int k = 0; k < 5; k++) chk($sformatf("fill6_v%0d", k), v_o[k], 6 - k);
      end
      hblank();
      chk("fill_lines", bus.lines_o, (L < 4) ? L : 4);
    end

    // Overflow: 1605 pixels, then two full lines to check alignment.
    chk("ovf_before", bus.ovf_o, 0);
    for (int n = 0; n < SW + 5; n++) pix((n < SW) ? pat(n) : 8'hEE);
    hblank();
    chk("ovf_set", bus.ovf_o, 1);
    for (int c = 0; c < SW; c++) begin
      pix(8'h33);
      if (c == 0)      chk("ovf_next_c0", v_o[1], 8'h5A);
      if (c == SW - 1) chk("ovf_next_c1599", v_o[1], 8'h65);
    end
    hblank();
    for (int c = 0; c < SW; c++) begin
      pix(8'h44);
      if (c == 0) begin
        chk("ovf_follow_v1", v_o[1], 8'h33);
        chk("ovf_follow_v2", v_o[2], 8'h5A);
      end
    end
    hblank();
    chk("ovf_sticky", bus.ovf_o, 1);

    // Coefficient stream: program ramp (plus an ignored out-of-range write), hold vsync 30.
    for (int i = 0; i < NC; i++) cyc(8'h00, 0, 0, 0, 1, 5'(i), 16'h0100 + 16'(i));
    cyc(8'h00, 0, 0, 0, 1, 5'd27, 16'hDEAD);
    idle(2);
    for (int j = 0; j < 30; j++) begin
      cyc(8'h00, 0, 0, 1, 0, 5'd0, 16'h0);
`ifdef LINEBUF_COEFF_EN
      chk($sformatf("stream%0d", j), bus.coeff_o, (j < NC) ? 16'h0100 + 16'(j) : 16'h0000);
`else
      chk($sformatf("stream%0d", j), bus.coeff_o, (j == 12) ? 16'h0100 : 16'h0000);
`endif
    end
    idle(3);

    // Bank swap race: write on the vsync rising-edge cycle lands next frame.
    cyc(8'h00, 0, 0, 1, 1, 5'd0, 16'h7FFF);
`ifdef LINEBUF_COEFF_EN
    chk("race_cur", bus.coeff_o, 16'h0100);
`else
    chk("race_cur", bus.coeff_o, 16'h0000);
`endif
    vsync(4); idle(3);
    cyc(8'h00, 0, 0, 1, 0, 5'd0, 16'h0);
`ifdef LINEBUF_COEFF_EN
    chk("race_next", bus.coeff_o, 16'h7FFF);
`else
    chk("race_next", bus.coeff_o, 16'h0000);
`endif
    idle(3);

    // Mid-frame reset during line 3, then rows must re-mask until 4 new lines.
    vsync(2); idle(2);
    for (int L = 1; L <= 2; L++) begin
      for (int c = 0; c < 64; c++) pix(8'h60 + 8'(L));
      hblank();
    end
    for (int c = 0; c < 20; c++) pix(8'h63);
    do_reset("midrst");
    for (int c = 0; c < 30; c++) pix(8'h70);
    hblank();
    chk("midrst_unsynced", bus.lines_o, 0);
    vsync(2); idle(2);
    for (int L = 1; L <= 5; L++) begin
      for (int c = 0; c < 64; c++) begin
        pix(8'h80 + 8'(L));
        if (c == 10 && L == 4) begin
          chk("midrst_l4_v3", v_o[3], 8'h81);
          chk("midrst_l4_v4", v_o[4], 8'h00);
        end
        if (c == 10 && L == 5) chk("midrst_l5_v4", v_o[4], 8'h81);
      end
      hblank();
    end

    // Random frames with random cfg traffic.
    for (int f = 0; f < 40; f++) begin
      vl = $urandom_range(1, 32);
      for (int j = 0; j < vl; j++) rcyc(8'($urandom), 0, 0, 1);
      rcyc(8'($urandom), 0, 0, 0);
      nl = $urandom_range(1, 6);
      for (int l = 0; l < nl; l++) begin
        rcyc(8'($urandom), 0, 1, 0);
        repeat ($urandom_range(1, 4)) rcyc(8'($urandom), 0, 0, 0);
        ll = $urandom_range(1, 48);
        for (int c = 0; c < ll; c++) rcyc(8'($urandom), 1, 0, 0);
      end
      rcyc(8'($urandom), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
